// File: rtl/ram_copy_engine.sv
// Word-by-word RAM copy engine: READ/WRITE pair per word (2*len busy cycles),
// or WRITE-only constant fill (len cycles) when built with RAM_COPY_FILL_EN.
module ram_copy_engine #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
`ifdef RAM_COPY_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
`endif
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic              fill_sel;
  logic [DATA_W-1:0] fill_val;

`ifdef RAM_COPY_FILL_EN
  assign fill_sel = fill;
  assign fill_val = fill_value;
`else
  assign fill_sel = 1'b0;
  assign fill_val = '0;
`endif

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] src_ptr_q,  src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q,  dst_ptr_d;
  logic [ADDR_W:0]   cnt_q,      cnt_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic              fill_q,     fill_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_in_q,   mem_in_d;
  logic              mem_load_q, mem_load_d;

  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            src_ptr_d  = src;
            dst_ptr_d  = dst;
            cnt_d      = len;
            fill_d     = fill_sel;
            fill_val_d = fill_val;
            state_d    = fill_sel ? WRITE : READ;
          end
        end
      end
      READ: begin
        data_d  = mem_out;
        state_d = WRITE;
      end
      WRITE: begin
        src_ptr_d = src_ptr_q + PTR_ONE;
        dst_ptr_d = dst_ptr_q + PTR_ONE;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = fill_q ? WRITE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    busy_d     = (state_d != IDLE);
    mem_load_d = (state_d == WRITE);
    mem_addr_d = '0;
    mem_in_d   = '0;
    if (state_d == READ) begin
      mem_addr_d = src_ptr_d;
    end else if (state_d == WRITE) begin
      mem_addr_d = dst_ptr_d;
      mem_in_d   = fill_d ? fill_val_d : data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      fill_q     <= 1'b0;
      fill_val_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
      mem_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_addr_q <= mem_addr_d;
      mem_in_q   <= mem_in_d;
      mem_load_q <= mem_load_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_addr = mem_addr_q;
  assign mem_in   = mem_in_q;
  assign mem_load = mem_load_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural 4K x 16 RAM model.
// Fill-mode steps are present only when RAM_COPY_FILL_EN is defined.
module tb_ram_copy_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] src;
  logic [11:0] dst;
  logic [12:0] len;
  logic [15:0] mem_out;
  logic        busy;
  logic        done;
  logic [11:0] mem_addr;
  logic [15:0] mem_in;
  logic        mem_load;
`ifdef RAM_COPY_FILL_EN
  logic        fill;
  logic [15:0] fill_value;
`endif

  ram_copy_engine #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src        (src),
    .dst        (dst),
    .len        (len),
`ifdef RAM_COPY_FILL_EN
    .fill       (fill),
    .fill_value (fill_value),
`endif
    .mem_out    (mem_out),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_in     (mem_in),
    .mem_load   (mem_load)
  );

  // RAM model: DUT writes win; bench preload port used only while DUT is idle.
  logic [15:0] mem [0:4095];
  logic        pl_we;
  logic [11:0] pl_addr;
  logic [15:0] pl_dat;

  assign mem_out = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_load) mem[mem_addr] <= mem_in;
    else if (pl_we) mem[pl_addr] <= pl_dat;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int busy_n, done_n, load_n, bad_n, done_at;
  logic [11:0] rd_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_dat  = d;
    pl_we   = 1'b1;
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the first post-start cycle.
  task automatic do_start(input logic [11:0] s, input logic [11:0] d, input logic [12:0] l);
    src   = s;
    dst   = d;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes ncyc cycles; optionally pulses start again at cycle inject_at.
  task automatic watch(input int ncyc, input int inject_at);
    busy_n = 0; done_n = 0; load_n = 0; bad_n = 0; done_at = -1;
    rd_q.delete();
    for (int i = 0; i < ncyc; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (mem_load) load_n++;
      if (mem_load && !busy) bad_n++;
      if (busy && !mem_load) rd_q.push_back(mem_addr);
      start = (i == inject_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    pl_we = 1'b0; pl_addr = '0; pl_dat = '0;
`ifdef RAM_COPY_FILL_EN
    fill = 1'b0; fill_value = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_done",  {31'b0, done}, 32'd0);
    chk("rst_load",  {31'b0, mem_load}, 32'd0);
    chk("rst_addr",  {20'b0, mem_addr}, 32'd0);
    chk("rst_din",   {16'b0, mem_in}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic copy of four words
    for (int i = 0; i < 4; i++) preload(12'h010 + 12'(i), 16'h1111 + 16'(i));
    do_start(12'h010, 12'h200, 13'd4);
    watch(12, -1);
    chk("cp_busy",    32'(busy_n), 32'd8);
    chk("cp_done_n",  32'(done_n), 32'd1);
    chk("cp_done_at", 32'(done_at), 32'd8);
    chk("cp_loads",   32'(load_n), 32'd4);
    chk("cp_bad",     32'(bad_n), 32'd0);
    chk("cp_nrd",     32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cp_rdaddr", {20'b0, rd_q[i]}, 32'h010 + 32'(i));
      chk("cp_word",   {16'b0, mem[12'h200 + 12'(i)]}, 32'h1111 + 32'(i));
    end

    // Zero-length request
    do_start(12'h010, 12'h900, 13'd0);
    watch(4, -1);
    chk("z_done_at", 32'(done_at), 32'd0);
    chk("z_done_n",  32'(done_n), 32'd1);
    chk("z_busy",    32'(busy_n), 32'd0);
    chk("z_loads",   32'(load_n), 32'd0);

    // Wrapping, overlapping copy: dst = src + 3, so word 4 replicates word 1
    preload(12'hFFE, 16'hA001);
    preload(12'hFFF, 16'hA002);
    preload(12'h000, 16'hA003);
    preload(12'h001, 16'hA004);
    preload(12'h002, 16'h0000);
    preload(12'h003, 16'h0000);
    preload(12'h004, 16'h0000);
    do_start(12'hFFE, 12'h001, 13'd4);
    watch(12, -1);
    chk("wr_busy",   32'(busy_n), 32'd8);
    chk("wr_done_n", 32'(done_n), 32'd1);
    chk("wr_nrd",    32'(rd_q.size()), 32'd4);
    chk("wr_rd0",    {20'b0, rd_q[0]}, 32'hFFE);
    chk("wr_rd1",    {20'b0, rd_q[1]}, 32'hFFF);
    chk("wr_rd2",    {20'b0, rd_q[2]}, 32'h000);
    chk("wr_rd3",    {20'b0, rd_q[3]}, 32'h001);
    chk("wr_m001",   {16'b0, mem[12'h001]}, 32'hA001);
    chk("wr_m002",   {16'b0, mem[12'h002]}, 32'hA002);
    chk("wr_m003",   {16'b0, mem[12'h003]}, 32'hA003);
    chk("wr_m004",   {16'b0, mem[12'h004]}, 32'hA001);

    // Reset during the third WRITE of an 8-word copy
    for (int i = 0; i < 8; i++) begin
      preload(12'h300 + 12'(i), 16'h3000 + 16'(i));
      preload(12'h400 + 12'(i), 16'h0000);
    end
    do_start(12'h300, 12'h400, 13'd8);
    repeat (5) @(negedge clk);
    chk("ab_in_write", {31'b0, mem_load}, 32'd1);
    chk("ab_waddr",    {20'b0, mem_addr}, 32'h402);
    rst_n = 1'b0;
    @(negedge clk);
    chk("ab_busy", {31'b0, busy}, 32'd0);
    chk("ab_done", {31'b0, done}, 32'd0);
    chk("ab_load", {31'b0, mem_load}, 32'd0);
    chk("ab_addr", {20'b0, mem_addr}, 32'd0);
    chk("ab_din",  {16'b0, mem_in}, 32'd0);
    rst_n = 1'b1;
    watch(8, -1);
    chk("ab_post_done", 32'(done_n), 32'd0);
    chk("ab_post_busy", 32'(busy_n), 32'd0);
    chk("ab_post_load", 32'(load_n), 32'd0);
    for (int i = 0; i < 3; i++)
      chk("ab_written", {16'b0, mem[12'h400 + 12'(i)]}, 32'h3000 + 32'(i));
    chk("ab_unwritten", {16'b0, mem[12'h403]}, 32'd0);

    // Second start mid-transfer must be ignored
    for (int i = 0; i < 3; i++) preload(12'h500 + 12'(i), 16'h5000 + 16'(i));
    preload(12'h800, 16'h0000);
    preload(12'h801, 16'h0000);
    do_start(12'h500, 12'h600, 13'd3);
    src = 12'h700; dst = 12'h800; len = 13'd2;
    watch(10, 2);
    chk("ig_busy",   32'(busy_n), 32'd6);
    chk("ig_done_n", 32'(done_n), 32'd1);
    chk("ig_done_at", 32'(done_at), 32'd6);
    chk("ig_loads",  32'(load_n), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("ig_word", {16'b0, mem[12'h600 + 12'(i)]}, 32'h5000 + 32'(i));
    chk("ig_m800", {16'b0, mem[12'h800]}, 32'd0);
    chk("ig_m801", {16'b0, mem[12'h801]}, 32'd0);

`ifdef RAM_COPY_FILL_EN
    // Constant fill wrapping past the top of memory
    fill = 1'b1;
    fill_value = 16'hBEEF;
    do_start(12'h123, 12'hFFF, 13'd3);
    fill = 1'b0;
    watch(6, -1);
    chk("fl_busy",    32'(busy_n), 32'd3);
    chk("fl_done_n",  32'(done_n), 32'd1);
    chk("fl_done_at", 32'(done_at), 32'd3);
    chk("fl_loads",   32'(load_n), 32'd3);
    chk("fl_nrd",     32'(rd_q.size()), 32'd0);
    chk("fl_mFFF",    {16'b0, mem[12'hFFF]}, 32'hBEEF);
    chk("fl_m000",    {16'b0, mem[12'h000]}, 32'hBEEF);
    chk("fl_m001",    {16'b0, mem[12'h001]}, 32'hBEEF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_copy_engine.md
RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

Interface
REQ-001 Parameter: ADDR_W, default 12, memory address width (4K words).
REQ-002 Parameter: DATA_W, default 16, memory word width.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  single-cycle request to begin a transfer.
REQ-006 Port: src  input  ADDR_W  first source word address, sampled with start.
REQ-007 Port: dst  input  ADDR_W  first destination word address, sampled with start.
REQ-008 Port: len  input  ADDR_W+1  word count, 0..4096, sampled with start.
REQ-009 Port: busy  output  1  transfer in progress.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: mem_addr  output  ADDR_W  drives the RAM address.
REQ-012 Port: mem_in  output  DATA_W  drives the RAM write data.
REQ-013 Port: mem_load  output  1  RAM write enable; RAM writes on the clk edge while high.
REQ-014 Port: mem_out  input  DATA_W  RAM read data, combinational from mem_addr.
REQ-015 Ports, only with RAM_COPY_FILL_EN: fill  input  1  fill mode select; fill_value  input  DATA_W  constant to write. Both sampled with start.

Function
REQ-016 The FSM SHALL have three states: IDLE, READ and WRITE.
REQ-017 In IDLE, start=1 with len!=0 SHALL latch src, dst and len, and SHALL move to READ. In fill mode it SHALL move to WRITE instead.
REQ-018 In IDLE, start=1 with len==0 SHALL give done=1 in the next cycle, SHALL leave busy=0 and SHALL make no memory access.
REQ-019 In READ: mem_addr=src_ptr, mem_load=0. On the clock edge, mem_out SHALL be captured into a data register and the FSM SHALL move to WRITE.
REQ-020 In WRITE: mem_addr=dst_ptr, mem_in=data register (fill_value in fill mode), mem_load=1.
REQ-021 On the WRITE edge, both pointers SHALL increment and the remaining count SHALL decrement.
REQ-022 After the WRITE edge, the FSM SHALL go to READ (WRITE in fill mode) if the remaining count is nonzero, else to IDLE.
REQ-023 Pointer increments SHALL wrap modulo 2^ADDR_W (4095 -> 0).
REQ-024 busy SHALL be 1 in every cycle the FSM is in READ or WRITE, and 0 in IDLE.
REQ-025 Copy latency SHALL be exactly 2*len busy cycles; fill latency SHALL be exactly len busy cycles.
REQ-026 done SHALL be 1 in exactly the first IDLE cycle after the final WRITE, and 0 otherwise.
REQ-027 start while busy=1 SHALL be ignored, with no effect on the transfer in progress.
REQ-028 Overlapping regions SHALL be copied strictly word-by-word in ascending order. With dst = src+k and 0<k<len, the first k source words therefore replicate; this is the defined behaviour.
REQ-029 In IDLE: mem_load=0, mem_addr=0, mem_in=0.
REQ-030 mem_load SHALL never be 1 outside WRITE.

Reset
REQ-031 rst_n=0 sampled on a clk edge SHALL force: IDLE state, busy=0, done=0, mem_load=0, mem_addr=0, mem_in=0, pointers=0, count=0, data register=0.
REQ-032 Reset mid-transfer SHALL abort the transfer, with no done pulse.
REQ-033 After a mid-transfer reset, mem_load=0 from the cycle following the reset edge; words already written stay written.
REQ-034 start SHALL be ignored in any cycle where rst_n=0.

Configuration
REQ-035 With RAM_COPY_FILL_EN defined: the fill and fill_value ports exist, and fill=1 at start SHALL write fill_value to len words from dst with no READ cycles.
REQ-036 Without RAM_COPY_FILL_EN: the fill and fill_value ports are absent, READ state is always entered, and all transfers are copies.

Verification
REQ-037 RAM preloaded with 0x1111..0x1114 at 0x010..0x013; start, src=0x010, dst=0x200, len=4 -> 0x200..0x203 = 0x1111..0x1114; busy 8 cycles; one done pulse.
REQ-038 Copy src=0xFFE, dst=0x001, len=4 -> source reads wrap 0xFFE, 0xFFF, 0x000, 0x001 in order; overlap follows REQ-028.
REQ-039 start with len=0 -> done=1 next cycle, busy=0, mem_load never 1.
REQ-040 Copy len=8; rst_n=0 during the 3rd WRITE -> exactly 3 words written, no done pulse, idle outputs are 0 next cycle.
REQ-041 Second start pulse mid-transfer with different src/dst -> ignored; the original transfer completes unchanged.
REQ-042 (RAM_COPY_FILL_EN) fill=1, fill_value=0xBEEF, dst=0xFFF, len=3 -> 0xFFF, 0x000, 0x001 = 0xBEEF; busy 3 cycles; done pulse.
